// File: rtl/divisor_frecuencia_prog.sv
// rtl/divisor_frecuencia_prog.sv - programmable 50% clock divider with glitch-free reload, edge strobes and frame counter
module divisor_frecuencia_prog #(
   parameter int CNT_W       = 8,
   parameter int DIV_DEFAULT = 4,
   parameter int FRAME_LEN   = 16,
   parameter int FRAME_W     = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic [CNT_W-1:0]   div_half,
   input  logic               div_load,
   output logic               load_ack,
   output logic               clk_out,
   output logic               rise_tick,
   output logic               fall_tick,
   output logic               frame_start,
   output logic [FRAME_W-1:0] bit_index
);

   localparam logic [CNT_W-1:0]   DEF_HALF = CNT_W'(DIV_DEFAULT);
   localparam logic [CNT_W-1:0]   ONE      = CNT_W'(1);
   localparam logic [FRAME_W-1:0] LAST_BIT = FRAME_W'(FRAME_LEN - 1);
   localparam logic [FRAME_W-1:0] BIT_ONE  = FRAME_W'(1);

   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   active_half;
   logic [CNT_W-1:0]   pend_half;
   logic               pend_valid;
   logic [FRAME_W-1:0] rise_cnt;

   logic [CNT_W-1:0]   req_half;
   logic [CNT_W-1:0]   apply_half;
   logic               toggle;
   logic               boundary;
   logic               do_apply;

   // A new ratio may only take over at the start of a low phase, so clk_out never glitches.
   always_comb begin
      req_half   = (div_half == '0) ? ONE : div_half;
      toggle     = enable && (cnt == active_half - ONE);
      boundary   = (toggle && clk_out) || (!enable && !clk_out);
      do_apply   = boundary && (div_load || pend_valid);
      apply_half = div_load ? req_half : pend_half;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt         <= '0;
         clk_out     <= 1'b0;
         active_half <= DEF_HALF;
         pend_half   <= DEF_HALF;
         pend_valid  <= 1'b0;
         rise_cnt    <= '0;
         bit_index   <= '0;
         rise_tick   <= 1'b0;
         fall_tick   <= 1'b0;
         frame_start <= 1'b0;
         load_ack    <= 1'b0;
      end else begin
         rise_tick   <= toggle && !clk_out;
         fall_tick   <= toggle && clk_out;
         frame_start <= toggle && !clk_out && (rise_cnt == '0);
         load_ack    <= do_apply;

         if (toggle)
            clk_out <= !clk_out;

         if (do_apply || toggle)
            cnt <= '0;
         else if (enable)
            cnt <= cnt + ONE;

         // A load arriving on the boundary itself supersedes any older pending value.
         if (do_apply) begin
            active_half <= apply_half;
            pend_valid  <= 1'b0;
         end else if (div_load) begin
            pend_half   <= req_half;
            pend_valid  <= 1'b1;
         end

         if (toggle && !clk_out) begin
            bit_index <= rise_cnt;
            rise_cnt  <= (rise_cnt == LAST_BIT) ? '0 : rise_cnt + BIT_ONE;
         end
      end
   end

endmodule

// File: doc/divisor_frecuencia_prog.md
# divisor_frecuencia_prog

Programmable, parametrised successor to the fixed ADC clock divider. It generates a 50 % duty-cycle `clk_out` from the system clock with a half-period that can be changed at runtime without glitches. It also produces edge strobes and frame/bit counters so the ADC serial interface can sample and frame data without extra logic. It sits between the system clock and the ADC capture logic of the equaliser.

## Interface
- `CNT_W`, 8: width of the half-period value and the internal counter.
- `DIV_DEFAULT`, 4: half-period in `clk` cycles, loaded at reset; must be ≥1.
- `FRAME_LEN`, 16: number of `clk_out` rising edges per ADC frame; must be ≥2.
- `FRAME_W`, 5: width of `bit_index`; must hold `FRAME_LEN-1`.
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  1 = divider runs; 0 = freeze.
- `div_half`  in  CNT_W  requested half-period in `clk` cycles; 0 is treated as 1.
- `div_load`  in  1  one-cycle request to latch `div_half`.
- `load_ack`  out  1  one-cycle pulse when a requested ratio becomes active.
- `clk_out`  out  1  divided clock.
- `rise_tick`  out  1  high for the one cycle in which `clk_out` has just become 1.
- `fall_tick`  out  1  high for the one cycle in which `clk_out` has just become 0.
- `frame_start`  out  1  asserted with `rise_tick` on the first rise of each frame.
- `bit_index`  out  FRAME_W  index of the latest rise within its frame, 0..FRAME_LEN-1; holds between rises.

## Operation
- **Reset state:**
  - Outputs: `clk_out`, `rise_tick`, `fall_tick`, `frame_start`, `load_ack` = 0; `bit_index` = 0.
  - Internal: `cnt` = 0, `active_half` = DIV_DEFAULT, `pend_valid` = 0, `rise_cnt` = 0.
- **Half-period counter (`enable`=1):**
  - If `cnt` == `active_half`-1: toggle `clk_out` and clear `cnt`.
  - Otherwise: increment `cnt`.
- **`enable`=0:**
  - `cnt` and `clk_out` hold.
  - All strobes are 0.
  - The ratio may still be applied (see below).
- **Ratio reload:**
  - `div_load`=1 stores max(`div_half`,1) as the pending value and sets `pend_valid`.
  - A later `div_load` before the pending value is applied overwrites it.
  - The pending value is applied only at a period boundary: on the toggle 1→0, or on any cycle with `enable`=0 and `clk_out`=0.
  - Applying sets `active_half` to the pending value, `cnt` to 0, and `pend_valid` to 0. `load_ack` pulses, registered together with the toggle.
- **Simultaneous `div_load` and boundary:** the incoming `div_half` is applied directly (it wins over the older pending value), `load_ack` pulses, and `pend_valid` ends at 0.
- **Rise handling** (on the toggle 0→1):
  - `bit_index` ← `rise_cnt`.
  - `frame_start` ← (`rise_cnt` == 0).
  - `rise_cnt` ← (`rise_cnt` == FRAME_LEN-1) ? 0 : `rise_cnt`+1.
- **Reset mid-operation:** returns to the reset state on the next edge; any pending ratio is discarded and `active_half` returns to DIV_DEFAULT.
- **Width rules:** `cnt` is CNT_W bits, so the maximum half-period is 2^CNT_W-1. There is no overflow because `cnt` is always compared against `active_half`-1.

## Timing
- All outputs are registered; none is combinational from the inputs.
- **Edge numbering:** edge 1 is the first `clk` edge with `reset`=0 and `enable`=1, active half-period H.
  - `clk_out` becomes 1 after edge H, 0 after edge 2H, then repeats with period 2H and exactly H cycles high and H cycles low.
  - `rise_tick` is high between edges H and H+1.
  - `fall_tick` is high between edges 2H and 2H+1.
- **H=1:** `clk_out` toggles every edge (period 2); `rise_tick` and `fall_tick` alternate every cycle.
- **Reload latency:** a new ratio takes effect from the first low phase after the next 1→0 toggle. The low phase that begins at that toggle already uses the new H.
- **Strobe alignment:** `load_ack` and `fall_tick` coincide when the ratio is applied at a falling toggle.
- **Frame period:** `frame_start` recurs every FRAME_LEN·2H cycles at constant H.

## Test plan
- **Reset defaults:** hold `reset` for 5 cycles with DIV_DEFAULT=4 → all outputs 0; with `enable`=1, `clk_out` is high after edges 4–7 and low after edges 8–11; `rise_tick` pulses at edge 4 and `fall_tick` at edge 8.
- **Reload mid-high phase:** `div_load` with `div_half`=2 at edge 5 (while `clk_out`=1) → toggle low at edge 8 with `load_ack`=1; next rise at edge 10, fall at edge 12; period becomes 4.
- **Frame wrap:** FRAME_LEN=16, H=4 → `frame_start` with `bit_index`=0 at rises 1, 17, 33 (every 128 cycles); `bit_index`=15 on rise 16.
- **Freeze and idle reload:** drop `enable` for 10 cycles while `clk_out`=1 → `clk_out` stays 1 with no strobes, then resumes the count where it stopped. Drop `enable` while `clk_out`=0 and pulse `div_load` with value 3 → `load_ack` on the next edge.
- **Zero ratio and collision:** `div_half`=0 loaded → behaves as H=1. Then assert `div_load` with value 6 exactly on a falling-toggle cycle while another value is pending → 6 is applied and `load_ack` is a single pulse.
- **Reset mid-operation:** assert `reset` mid-frame with a ratio pending → all outputs 0 next cycle; after release, the period is 2·DIV_DEFAULT and the first rise gives `bit_index`=0 with `frame_start`=1.
